// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_pkg
// Description : Shared RV32I opcode, write-back, immediate and ALU encodings
//               plus the decoded control bundle carried by the decode queue.
// Revision    : 1.0 - registered decode pipe with bundle queue
// ============================================================================
package msrv32_pkg;

    // Full 7-bit major opcodes (low bits 11 included)
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct7 values accepted on the OP major opcode
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Write-back source select
    localparam logic [2:0] WB_ALU    = 3'b000;
    localparam logic [2:0] WB_LOAD   = 3'b001;
    localparam logic [2:0] WB_IMM    = 3'b010;
    localparam logic [2:0] WB_IADDER = 3'b011;
    localparam logic [2:0] WB_CSR    = 3'b100;
    localparam logic [2:0] WB_PC4    = 3'b101;

    // Immediate format select
    localparam logic [2:0] IMM_R   = 3'b000;
    localparam logic [2:0] IMM_I   = 3'b001;
    localparam logic [2:0] IMM_S   = 3'b010;
    localparam logic [2:0] IMM_B   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_J   = 3'b101;
    localparam logic [2:0] IMM_CSR = 3'b110;

    // ALU operation default for non-ALU instructions (address/add path)
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    // Decoded control bundle, one queue entry per accepted instruction
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  wb_mux_sel;
        logic [2:0]  imm_type;
        logic [2:0]  csr_op;
        logic [3:0]  alu_opcode;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic        mem_wr_req;
        logic        alu_src;
        logic        iadder_src;
        logic        csr_wr_en;
        logic        rf_wr_en;
        logic        mul_div_en;
        logic        illegal_instr;
        logic        misaligned_load;
        logic        misaligned_store;
    } dec_bundle_t;

    localparam int DEC_BUNDLE_W = $bits(dec_bundle_t);

endpackage
`default_nettype wire

// File: rtl/msrv32_decode_fifo.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_decode_fifo
// Description : Generic WIDTH x DEPTH synchronous FIFO with flush. Pointers
//               carry one extra wrap bit so full and empty are distinct.
//               No pop-to-push bypass: a full FIFO refuses writes.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_rdata   = r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Pointer update; flush empties the queue and overrides push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/msrv32_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_decode_pipe
// Description : Registered RV32I decoder. Decodes the offered instruction
//               combinationally, queues the control bundle in a small FIFO
//               and presents the head to execute. Optional RV32M / CSR
//               recognition, trap flush and saturating illegal counter.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_decode_pipe
    import msrv32_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter bit ENABLE_M   = 1'b0,
    parameter bit ENABLE_CSR = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             trap_taken_in,
    input  logic             instr_valid_in,
    output logic             instr_ready_out,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic [1:0]       iadder_out_1_to_0_in,
    output logic             dec_valid_out,
    input  logic             dec_ready_in,
    output logic [31:0]      pc_out,
    output logic [2:0]       wb_mux_sel_out,
    output logic [2:0]       imm_type_out,
    output logic [2:0]       csr_op_out,
    output logic [3:0]       alu_opcode_out,
    output logic [1:0]       load_size_out,
    output logic             load_unsigned_out,
    output logic             mem_wr_req_out,
    output logic             alu_src_out,
    output logic             iadder_src_out,
    output logic             csr_wr_en_out,
    output logic             rf_wr_en_out,
    output logic             mul_div_en_out,
    output logic             illegal_instr_out,
    output logic             misaligned_load_out,
    output logic             misaligned_store_out,
    output logic [CNT_W-1:0] illegal_cnt_out
);

    logic [6:0]              w_opcode;
    logic [2:0]              w_funct3;
    logic [6:0]              w_funct7;
    logic                    w_misaligned;
    dec_bundle_t             w_dec;
    logic [DEC_BUNDLE_W-1:0] w_head_raw;
    dec_bundle_t             w_head;
    dec_bundle_t             w_out;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [CNT_W-1:0]        r_illegal_cnt;
    logic                    w_unused_bits;

    assign w_opcode = instr_in[6:0];
    assign w_funct3 = instr_in[14:12];
    assign w_funct7 = instr_in[31:25];

    // Register-index fields are consumed by the register file, not here
    assign w_unused_bits = ^{instr_in[24:15], instr_in[11:7]};

    // Half-word needs bit0 clear, word needs both low bits clear
    assign w_misaligned = ((w_funct3[1:0] == 2'b01) && iadder_out_1_to_0_in[0]) ||
                          ((w_funct3[1:0] == 2'b10) && (iadder_out_1_to_0_in != 2'b00));

    // Combinational decode of the offered instruction into a bundle
    always_comb begin
        w_dec               = '0;
        w_dec.pc            = pc_in;
        w_dec.load_size     = w_funct3[1:0];
        w_dec.load_unsigned = w_funct3[2];
        w_dec.alu_opcode    = ALU_ADD;
        case (w_opcode)
            OPC_LUI: begin
                w_dec.wb_mux_sel = WB_IMM;
                w_dec.imm_type   = IMM_U;
                w_dec.rf_wr_en   = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.wb_mux_sel = WB_IADDER;
                w_dec.imm_type   = IMM_U;
                w_dec.rf_wr_en   = 1'b1;
            end
            OPC_JAL: begin
                w_dec.wb_mux_sel = WB_PC4;
                w_dec.imm_type   = IMM_J;
                w_dec.rf_wr_en   = 1'b1;
            end
            OPC_JALR: begin
                w_dec.wb_mux_sel = WB_PC4;
                w_dec.imm_type   = IMM_I;
                w_dec.iadder_src = 1'b1;
                w_dec.rf_wr_en   = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.imm_type      = IMM_B;
                w_dec.illegal_instr = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OPC_LOAD: begin
                w_dec.wb_mux_sel      = WB_LOAD;
                w_dec.imm_type        = IMM_I;
                w_dec.iadder_src      = 1'b1;
                w_dec.rf_wr_en        = 1'b1;
                w_dec.misaligned_load = w_misaligned;
                w_dec.illegal_instr   = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                        (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_dec.imm_type         = IMM_S;
                w_dec.iadder_src       = 1'b1;
                w_dec.mem_wr_req       = 1'b1;
                w_dec.misaligned_store = w_misaligned;
                w_dec.illegal_instr    = (w_funct3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                w_dec.imm_type   = IMM_I;
                w_dec.alu_src    = 1'b1;
                w_dec.rf_wr_en   = 1'b1;
                // Only the shift-right form uses bit 30 to pick arithmetic
                w_dec.alu_opcode = {(w_funct3 == 3'b101) && instr_in[30], w_funct3};
            end
            OPC_OP: begin
                w_dec.imm_type   = IMM_R;
                w_dec.rf_wr_en   = 1'b1;
                w_dec.alu_opcode = {instr_in[30], w_funct3};
                if (w_funct7 == F7_BASE) begin
                    w_dec.illegal_instr = 1'b0;
                end else if ((w_funct7 == F7_ALT) &&
                             ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
                    w_dec.illegal_instr = 1'b0;
                end else if ((w_funct7 == F7_MULDIV) && ENABLE_M) begin
                    w_dec.mul_div_en = 1'b1;
                end else begin
                    w_dec.illegal_instr = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                w_dec.imm_type = IMM_I;
            end
            OPC_SYSTEM: begin
                w_dec.imm_type = IMM_CSR;
                w_dec.csr_op   = w_funct3;
                if (w_funct3 != 3'b000) begin
                    w_dec.wb_mux_sel    = WB_CSR;
                    w_dec.rf_wr_en      = 1'b1;
                    w_dec.csr_wr_en     = 1'b1;
                    w_dec.illegal_instr = !ENABLE_CSR;
                end
            end
            default: begin
                w_dec.illegal_instr = 1'b1;
            end
        endcase
        // Any exception must not leave architectural side effects
        if (w_dec.illegal_instr || w_dec.misaligned_load || w_dec.misaligned_store) begin
            w_dec.rf_wr_en   = 1'b0;
            w_dec.mem_wr_req = 1'b0;
            w_dec.csr_wr_en  = 1'b0;
            w_dec.mul_div_en = 1'b0;
        end
    end

    assign instr_ready_out = !w_full;
    assign w_push          = instr_valid_in && instr_ready_out && !trap_taken_in;
    assign w_pop           = dec_valid_out && dec_ready_in && !trap_taken_in;

    msrv32_decode_fifo #(
        .WIDTH (DEC_BUNDLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ms_riscv32_mp_clk_in),
        .rst     (ms_riscv32_mp_rst_in),
        .i_flush (trap_taken_in),
        .i_push  (w_push),
        .i_wdata (w_dec),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dec_valid_out = !w_empty;
    assign w_head        = w_head_raw;
    // Outputs read as zero whenever nothing valid is at the head
    assign w_out         = dec_valid_out ? w_head : '0;

    assign pc_out               = w_out.pc;
    assign wb_mux_sel_out       = w_out.wb_mux_sel;
    assign imm_type_out         = w_out.imm_type;
    assign csr_op_out           = w_out.csr_op;
    assign alu_opcode_out       = w_out.alu_opcode;
    assign load_size_out        = w_out.load_size;
    assign load_unsigned_out    = w_out.load_unsigned;
    assign mem_wr_req_out       = w_out.mem_wr_req;
    assign alu_src_out          = w_out.alu_src;
    assign iadder_src_out       = w_out.iadder_src;
    assign csr_wr_en_out        = w_out.csr_wr_en;
    assign rf_wr_en_out         = w_out.rf_wr_en;
    assign mul_div_en_out       = w_out.mul_div_en;
    assign illegal_instr_out    = w_out.illegal_instr;
    assign misaligned_load_out  = w_out.misaligned_load;
    assign misaligned_store_out = w_out.misaligned_store;

    // Count accepted illegal instructions, holding at all-ones; flush keeps it
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_illegal_cnt <= '0;
        end else if (w_push && w_dec.illegal_instr && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign illegal_cnt_out = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_decode_pipe
// Description : Self-checking bench for msrv32_decode_pipe. Two instances
//               share stimulus: base config (M off, CSR on, 16-bit counter)
//               and alternate config (M on, CSR off, 3-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_decode_pipe;

    localparam logic [6:0] L_LUI = 7'h37, L_AUIPC = 7'h17, L_JAL = 7'h6F, L_JALR = 7'h67;
    localparam logic [6:0] L_BR  = 7'h63, L_LOAD  = 7'h03, L_ST  = 7'h23, L_OPI  = 7'h13;
    localparam logic [6:0] L_OP  = 7'h33, L_MISC  = 7'h0F, L_SYS = 7'h73;
    localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [1:0]  ia;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap = 1'b0;
    logic        ivalid = 1'b0;
    logic        dready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [1:0]  ia = '0;

    logic        ready0, valid0, lu0, mw0, as0, is0, cw0, rw0, md0, il0, ml0, ms0;
    logic [31:0] pc_out0;
    logic [2:0]  wb0, imm0, csr0;
    logic [3:0]  alu0;
    logic [1:0]  ls0;
    logic [15:0] cnt0;
    logic        ready1, valid1, lu1, mw1, as1, is1, cw1, rw1, md1, il1, ml1, ms1;
    logic [31:0] pc_out1;
    logic [2:0]  wb1, imm1, csr1;
    logic [3:0]  alu1;
    logic [1:0]  ls1;
    logic [2:0]  cnt1;
    logic [56:0] obs0, obs1;

    rec_t        q[$];
    logic [15:0] exp_cnt0 = '0;
    logic [2:0]  exp_cnt1 = '0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    msrv32_decode_pipe dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .trap_taken_in(trap),
        .instr_valid_in(ivalid), .instr_ready_out(ready0), .instr_in(instr), .pc_in(pc),
        .iadder_out_1_to_0_in(ia), .dec_valid_out(valid0), .dec_ready_in(dready),
        .pc_out(pc_out0), .wb_mux_sel_out(wb0), .imm_type_out(imm0), .csr_op_out(csr0),
        .alu_opcode_out(alu0), .load_size_out(ls0), .load_unsigned_out(lu0),
        .mem_wr_req_out(mw0), .alu_src_out(as0), .iadder_src_out(is0), .csr_wr_en_out(cw0),
        .rf_wr_en_out(rw0), .mul_div_en_out(md0), .illegal_instr_out(il0),
        .misaligned_load_out(ml0), .misaligned_store_out(ms0), .illegal_cnt_out(cnt0));

    msrv32_decode_pipe #(.FIFO_DEPTH(2), .ENABLE_M(1'b1), .ENABLE_CSR(1'b0), .CNT_W(3)) dut_m (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .trap_taken_in(trap),
        .instr_valid_in(ivalid), .instr_ready_out(ready1), .instr_in(instr), .pc_in(pc),
        .iadder_out_1_to_0_in(ia), .dec_valid_out(valid1), .dec_ready_in(dready),
        .pc_out(pc_out1), .wb_mux_sel_out(wb1), .imm_type_out(imm1), .csr_op_out(csr1),
        .alu_opcode_out(alu1), .load_size_out(ls1), .load_unsigned_out(lu1),
        .mem_wr_req_out(mw1), .alu_src_out(as1), .iadder_src_out(is1), .csr_wr_en_out(cw1),
        .rf_wr_en_out(rw1), .mul_div_en_out(md1), .illegal_instr_out(il1),
        .misaligned_load_out(ml1), .misaligned_store_out(ms1), .illegal_cnt_out(cnt1));

    assign obs0 = {pc_out0, wb0, imm0, csr0, alu0, ls0, lu0, mw0, as0, is0, cw0, rw0, md0, il0, ml0, ms0};
    assign obs1 = {pc_out1, wb1, imm1, csr1, alu1, ls1, lu1, mw1, as1, is1, cw1, rw1, md1, il1, ml1, ms1};

    // Reference decode: instruction-class rules straight from the ISA description
    function automatic logic [56:0] ref_dec(input logic [31:0] ins, input logic [31:0] pcv,
                                            input logic [1:0] iav, input bit en_m, input bit en_csr);
        logic [6:0] op;
        logic [2:0] f3, wb, imm, cop;
        logic [6:0] f7;
        logic [3:0] alu;
        logic known, csr_form, ill, mis, mla, mst, exc, rf, mw, cw, md;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        known    = op inside {L_LUI, L_AUIPC, L_JAL, L_JALR, L_BR, L_LOAD, L_ST, L_OPI, L_OP, L_MISC, L_SYS};
        csr_form = (op == L_SYS) && (f3 != 3'd0);
        wb = (op == L_LOAD) ? 3'd1 : (op == L_LUI) ? 3'd2 : (op == L_AUIPC) ? 3'd3 :
             (op == L_JAL || op == L_JALR) ? 3'd5 : csr_form ? 3'd4 : 3'd0;
        imm = (op == L_LUI || op == L_AUIPC) ? 3'd4 : (op == L_JAL) ? 3'd5 :
              (op inside {L_JALR, L_LOAD, L_OPI, L_MISC}) ? 3'd1 : (op == L_ST) ? 3'd2 :
              (op == L_BR) ? 3'd3 : (op == L_SYS) ? 3'd6 : 3'd0;
        cop = (op == L_SYS) ? f3 : 3'd0;
        alu = (op == L_OP) ? {ins[30], f3} : (op == L_OPI) ? {(f3 == 3'd5) & ins[30], f3} : 4'd0;
        ill = (ins[1:0] != 2'b11) || !known ||
              (op == L_BR && (f3 == 3'd2 || f3 == 3'd3)) ||
              (op == L_LOAD && (f3 == 3'd3 || f3 >= 3'd6)) ||
              (op == L_ST && f3 >= 3'd3) ||
              (op == L_OP && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                               (f7 == 7'h01 && en_m))) ||
              (csr_form && !en_csr);
        mis = (f3[1:0] == 2'd1 && iav[0]) || (f3[1:0] == 2'd2 && iav != 2'd0);
        mla = (op == L_LOAD) && mis;
        mst = (op == L_ST) && mis;
        exc = ill || mla || mst;
        rf  = !exc && ((op inside {L_LUI, L_AUIPC, L_JAL, L_JALR, L_LOAD, L_OPI, L_OP}) || csr_form);
        mw  = !exc && (op == L_ST);
        cw  = !exc && csr_form;
        md  = !exc && en_m && (op == L_OP) && (f7 == 7'h01);
        return {pcv, wb, imm, cop, alu, f3[1:0], f3[2], mw, (op == L_OPI),
                (op inside {L_JALR, L_LOAD, L_ST}), cw, rf, md, ill, mla, mst};
    endfunction

    function automatic logic [56:0] exp_head(input bit en_m, input bit en_csr);
        if (q.size() == 0) return '0;
        return ref_dec(q[0].ins, q[0].pc, q[0].ia, en_m, en_csr);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) r[6:0] = OPS[k];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    // One clock edge; the model mirrors queue and counter effects of that edge
    task automatic cycle();
        logic acc, pop, fl;
        logic [56:0] d0, d1;
        rec_t r;
        fl  = trap;
        acc = ivalid && (q.size() < DEPTH) && !trap;
        pop = (q.size() > 0) && dready && !trap;
        r.ins = instr; r.pc = pc; r.ia = ia;
        d0 = ref_dec(instr, pc, ia, 1'b0, 1'b1);
        d1 = ref_dec(instr, pc, ia, 1'b1, 1'b0);
        @(posedge clk); #1;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(r);
        end
        if (acc && d0[2] && exp_cnt0 != 16'hFFFF) exp_cnt0 = exp_cnt0 + 16'd1;
        if (acc && d1[2] && exp_cnt1 != 3'd7) exp_cnt1 = exp_cnt1 + 3'd1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [1:0] iav);
        logic [31:0] p;
        p = $urandom; p[1:0] = 2'b00;
        ivalid = 1'b1; instr = ins; ia = iav; pc = p; dready = 1'b0; trap = 1'b0;
        cycle();
        ivalid = 1'b0;
    endtask

    task automatic pop_one();
        dready = 1'b1; ivalid = 1'b0;
        cycle();
        dready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (valid0 !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid0); else n_pass++;
        n_total++; if (ready0 !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready0); else n_pass++;
        n_total++; if (cnt0 !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", cnt0); else n_pass++;
        n_total++; if (obs0 !== 57'd0) $display("FAIL rst_bundle0: got %h want 0", obs0); else n_pass++;
        n_total++; if (obs1 !== 57'd0) $display("FAIL rst_bundle1: got %h want 0", obs1); else n_pass++;
        n_total++; if (ready1 !== 1'b1) $display("FAIL rst_ready1: got %b want 1", ready1); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_alu_decode();
        issue(32'h002081B3, 2'b00);
        n_total++; if (valid0 !== 1'b1) $display("FAIL add_valid: got %b want 1", valid0); else n_pass++;
        n_total++; if ({alu0, imm0, wb0} !== 10'b0000_000_000) $display("FAIL add_fields: got %b want 0", {alu0, imm0, wb0}); else n_pass++;
        n_total++; if ({rw0, il0} !== 2'b10) $display("FAIL add_rf_ill: got %b want 10", {rw0, il0}); else n_pass++;
        n_total++; if (pc_out0 !== pc) $display("FAIL add_pc: got %h want %h", pc_out0, pc); else n_pass++;
        pop_one();
        issue(32'h402081B3, 2'b00);
        n_total++; if (alu0 !== 4'b1000) $display("FAIL sub_alu: got %b want 1000", alu0); else n_pass++;
        pop_one();
        issue(32'h4030D093, 2'b00);
        n_total++; if ({alu0, as0} !== 5'b1101_1) $display("FAIL srai_alu: got %b want 11011", {alu0, as0}); else n_pass++;
        pop_one();
        issue(32'h40308093, 2'b00);
        n_total++; if (alu0 !== 4'b0000) $display("FAIL addi_alu: got %b want 0000", alu0); else n_pass++;
        pop_one();
    endtask

    task automatic test_mem_decode();
        issue(32'h0000A103, 2'b10);
        n_total++; if ({ml0, rw0, il0} !== 3'b100) $display("FAIL lw_mis: got %b want 100", {ml0, rw0, il0}); else n_pass++;
        pop_one();
        issue(32'h00009103, 2'b10);
        n_total++; if ({ml0, ls0, rw0, wb0} !== 7'b0_01_1_001) $display("FAIL lh_ok: got %b want 0011001", {ml0, ls0, rw0, wb0}); else n_pass++;
        pop_one();
        issue(32'h0020A023, 2'b01);
        n_total++; if ({ms0, mw0} !== 2'b10) $display("FAIL sw_mis: got %b want 10", {ms0, mw0}); else n_pass++;
        pop_one();
        issue(32'h0020A023, 2'b00);
        n_total++; if ({ms0, mw0, imm0} !== 5'b01_010) $display("FAIL sw_ok: got %b want 01010", {ms0, mw0, imm0}); else n_pass++;
        pop_one();
    endtask

    task automatic test_illegal();
        issue(32'h00000000, 2'b00);
        n_total++; if ({il0, rw0} !== 2'b10) $display("FAIL zero_ill: got %b want 10", {il0, rw0}); else n_pass++;
        n_total++; if (cnt0 !== 16'd1) $display("FAIL zero_cnt: got %0d want 1", cnt0); else n_pass++;
        pop_one();
        issue(32'h022081B3, 2'b00);
        n_total++; if ({il0, md0} !== 2'b10) $display("FAIL mul_base: got %b want 10", {il0, md0}); else n_pass++;
        n_total++; if ({il1, md1, rw1} !== 3'b011) $display("FAIL mul_m: got %b want 011", {il1, md1, rw1}); else n_pass++;
        n_total++; if ({cnt0, cnt1} !== {16'd2, 3'd1}) $display("FAIL mul_cnt: got %0d/%0d want 2/1", cnt0, cnt1); else n_pass++;
        pop_one();
        issue(32'h30529073, 2'b00);
        n_total++; if ({il0, cw0, wb0, imm0, csr0} !== 11'b0_1_100_110_001) $display("FAIL csr_base: got %b want 01100110001", {il0, cw0, wb0, imm0, csr0}); else n_pass++;
        n_total++; if ({il1, cw1, cnt1} !== 5'b1_0_010) $display("FAIL csr_off: got %b want 10010", {il1, cw1, cnt1}); else n_pass++;
        pop_one();
    endtask

    task automatic test_fifo_full();
        dready = 1'b0; ivalid = 1'b1; instr = 32'h002081B3; ia = 2'b00;
        pc = 32'h100; cycle();
        n_total++; if ({valid0, ready0, pc_out0} !== {2'b11, 32'h100}) $display("FAIL ff_first: got %b %h want 11 100", {valid0, ready0}, pc_out0); else n_pass++;
        pc = 32'h104; cycle();
        n_total++; if ({ready0, ready1} !== 2'b00) $display("FAIL ff_full: got %b want 00", {ready0, ready1}); else n_pass++;
        pc = 32'h108; cycle();
        n_total++; if ({ready0, pc_out0} !== {1'b0, 32'h100}) $display("FAIL ff_refuse: got %b %h want 0 100", ready0, pc_out0); else n_pass++;
        dready = 1'b1; cycle();
        n_total++; if ({ready0, pc_out0} !== {1'b1, 32'h104}) $display("FAIL ff_pop_a: got %b %h want 1 104", ready0, pc_out0); else n_pass++;
        cycle();
        n_total++; if ({valid0, pc_out0} !== {1'b1, 32'h108}) $display("FAIL ff_accept_c: got %b %h want 1 108", valid0, pc_out0); else n_pass++;
        pc = 32'h10C; cycle();
        n_total++; if ({valid0, ready0, pc_out0} !== {2'b11, 32'h10C}) $display("FAIL ff_pushpop: got %b %h want 11 10c", {valid0, ready0}, pc_out0); else n_pass++;
        ivalid = 1'b0; cycle();
        n_total++; if (valid0 !== 1'b0) $display("FAIL ff_drain: got %b want 0", valid0); else n_pass++;
        dready = 1'b0;
    endtask

    task automatic test_flush();
        logic [15:0] cnt_before;
        dready = 1'b0; ivalid = 1'b1; instr = 32'h002081B3;
        pc = 32'h200; cycle();
        pc = 32'h204; cycle();
        n_total++; if ({valid0, ready0} !== 2'b10) $display("FAIL fl_setup: got %b want 10", {valid0, ready0}); else n_pass++;
        cnt_before = cnt0;
        trap = 1'b1; ivalid = 1'b1; instr = 32'h00000000; dready = 1'b1; pc = 32'h208;
        cycle();
        trap = 1'b0; ivalid = 1'b0; dready = 1'b0;
        n_total++; if ({valid0, ready0, valid1} !== 3'b010) $display("FAIL fl_empty: got %b want 010", {valid0, ready0, valid1}); else n_pass++;
        n_total++; if (cnt0 !== cnt_before) $display("FAIL fl_cnt: got %0d want %0d", cnt0, cnt_before); else n_pass++;
        cycle();
        n_total++; if (valid0 !== 1'b0) $display("FAIL fl_noaccept: got %b want 0", valid0); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ivalid = ($urandom_range(0, 3) != 0);
            dready = $urandom_range(0, 1);
            trap   = ($urandom_range(0, 15) == 0);
            instr  = rand_instr();
            pc     = $urandom;
            ia     = 2'($urandom_range(0, 3));
            n_total++; if ({ready0, ready1} !== {2{q.size() < DEPTH}}) $display("FAIL rnd_ready[%0d]: got %b want %b", i, {ready0, ready1}, {2{q.size() < DEPTH}}); else n_pass++;
            cycle();
            n_total++; if ({valid0, valid1} !== {2{q.size() > 0}}) $display("FAIL rnd_valid[%0d]: got %b want %b", i, {valid0, valid1}, {2{q.size() > 0}}); else n_pass++;
            n_total++; if (obs0 !== exp_head(1'b0, 1'b1)) $display("FAIL rnd_bundle0[%0d]: got %h want %h", i, obs0, exp_head(1'b0, 1'b1)); else n_pass++;
            n_total++; if (obs1 !== exp_head(1'b1, 1'b0)) $display("FAIL rnd_bundle1[%0d]: got %h want %h", i, obs1, exp_head(1'b1, 1'b0)); else n_pass++;
            n_total++; if ({cnt0, cnt1} !== {exp_cnt0, exp_cnt1}) $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, cnt0, cnt1, exp_cnt0, exp_cnt1); else n_pass++;
        end
        trap = 1'b0; ivalid = 1'b0; dready = 1'b1;
        repeat (3) cycle();
        dready = 1'b0;
    endtask

    task automatic test_saturation();
        dready = 1'b1; ivalid = 1'b1; instr = 32'h00000000; ia = 2'b00;
        repeat (10) cycle();
        ivalid = 1'b0;
        repeat (3) cycle();
        dready = 1'b0;
        n_total++; if (cnt1 !== 3'd7) $display("FAIL sat_cnt1: got %0d want 7", cnt1); else n_pass++;
        n_total++; if (cnt0 !== exp_cnt0) $display("FAIL sat_cnt0: got %0d want %0d", cnt0, exp_cnt0); else n_pass++;
    endtask

    task automatic test_async_reset();
        dready = 1'b0; ivalid = 1'b1; instr = 32'h002081B3; ia = 2'b00;
        pc = 32'h300; cycle();
        pc = 32'h304; cycle();
        ivalid = 1'b0;
        n_total++; if (valid0 !== 1'b1) $display("FAIL ar_setup: got %b want 1", valid0); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if ({valid0, ready0, valid1} !== 3'b010) $display("FAIL ar_flags: got %b want 010", {valid0, ready0, valid1}); else n_pass++;
        n_total++; if ({obs0, obs1} !== 114'd0) $display("FAIL ar_bundle: got %h %h want 0", obs0, obs1); else n_pass++;
        n_total++; if ({cnt0, cnt1} !== 19'd0) $display("FAIL ar_cnt: got %0d/%0d want 0", cnt0, cnt1); else n_pass++;
        q.delete(); exp_cnt0 = '0; exp_cnt1 = '0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_decode();
        test_mem_decode();
        test_illegal();
        test_fifo_full();
        test_flush();
        test_random();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msrv32_decode_pipe.md
Name: msrv32_decode_pipe

Overview:
Registered, parametrised successor to the combinational RV32I decoder.
- Accepts fetched instructions with the instruction-address adder's low bits through a valid/ready handshake.
- Decodes each instruction into the existing control bundle and buffers results in a FIFO_DEPTH-entry queue, so fetch can run ahead of a stalled execute stage.
- Adds optional RV32M recognition, an optional CSR mode, trap flush, and a saturating illegal-instruction counter.
- Sits between the IF/ID register and the execute/writeback stages.

Parameters:
FIFO_DEPTH, 2, decoded-bundle buffer entries; power of two, ≥2
ENABLE_M, 0, 1 = decode RV32M (OP, funct7=0000001) as legal
ENABLE_CSR, 1, 0 = SYSTEM CSR forms (funct3≠000) are illegal
CNT_W, 16, illegal-instruction counter width

Ports:
ms_riscv32_mp_clk_in  input  1  clock
ms_riscv32_mp_rst_in  input  1  asynchronous active-high reset
trap_taken_in  input  1  flush: discard queue and same-cycle input
instr_valid_in  input  1  instruction offered
instr_ready_out  output  1  decode can accept
instr_in  input  32  instruction word
pc_in  input  32  instruction PC
iadder_out_1_to_0_in  input  2  low bits of computed load/store address
dec_valid_out  output  1  head bundle valid
dec_ready_in  input  1  execute consumes head
pc_out  output  32  PC of head
wb_mux_sel_out  output  3  000 alu, 001 load, 010 imm, 011 iadder, 100 csr, 101 pc+4
imm_type_out  output  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 CSR
csr_op_out  output  3  funct3 for SYSTEM, else 000
alu_opcode_out  output  4  {funct7[5], funct3}
load_size_out  output  2  funct3[1:0]
load_unsigned_out  output  1  funct3[2]
mem_wr_req_out, alu_src_out, iadder_src_out, csr_wr_en_out, rf_wr_en_out  output  1 each  control
mul_div_en_out  output  1  RV32M op (always 0 when ENABLE_M=0)
illegal_instr_out, misaligned_load_out, misaligned_store_out  output  1 each  exception flags
illegal_cnt_out  output  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (async, active-high):
  - Queue empty; dec_valid_out=0; illegal_cnt_out=0.
  - All bundle outputs are 0 while dec_valid_out=0; fields are don't-care to the consumer.
  - instr_ready_out=1 after reset.
- Accept (push):
  - Occurs on a clock edge with instr_valid_in & instr_ready_out & !trap_taken_in.
  - Decode is combinational from the inputs; the bundle is written into the queue.
- Latency: an instruction accepted at edge N appears at the head with dec_valid_out=1 after edge N (one cycle) when the queue was empty.
- instr_ready_out = !full. There is no same-cycle pop bypass: a full queue refuses input even if dec_ready_in=1.
- Pop: dec_valid_out & dec_ready_in. Simultaneous push and pop are both performed and the count is unchanged. Queue order is strict FIFO.
- Pointers: log2(FIFO_DEPTH) bits plus a wrap bit. Full and empty are distinguished by the wrap bit. Pointers wrap modulo depth.
- Flush: trap_taken_in=1 clears pointers at the next edge.
  - Same-cycle push and pop are both suppressed.
  - illegal_cnt_out is retained.
- Decode rules:
  - alu_opcode_out:
    - OP: {instr[30], funct3}.
    - OP-IMM: {instr[30] only when funct3=101, else 0, funct3}.
    - All others: 0000 (add).
  - Illegal when any of the following holds:
    - instr[1:0]≠11.
    - Opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
    - Bad funct3 (BRANCH 010/011, LOAD 011/110/111, STORE ≥011).
    - Bad funct7 (OP funct7 other than 0000000, or 0100000 outside ADD/SRA, or 0000001 with ENABLE_M=0).
    - CSR with ENABLE_CSR=0.
  - misaligned_load_out: LOAD with half-word size and bit0=1, or word size and bits≠00. misaligned_store_out uses the same rule for STORE.
  - When any exception flag is set, rf_wr_en_out, mem_wr_req_out, csr_wr_en_out and mul_div_en_out are forced 0 in the bundle.
- illegal_cnt_out increments on each accepted illegal instruction and saturates at all-ones.

Decomposition:
- Package msrv32_pkg holds:
  - Opcode localparams.
  - WB_*, IMM_* and ALU_* encodings.
  - The decoded-bundle struct/width constant.
- Sub-module msrv32_decode_fifo: generic WIDTH×DEPTH synchronous FIFO with flush. It is instantiated with the bundle width.
- The decode logic stays in the top module.

Test Plan:
- ADD 0x002081B3 with dec_ready_in=1 → one cycle later: dec_valid_out=1, alu_opcode 0000, imm_type 000, wb_mux_sel 000, rf_wr_en 1, illegal 0.
- SUB 0x402081B3 → alu_opcode 1000; SRAI 0x4030D093 → alu_opcode 1101, alu_src 1; ADDI 0x40308093 → alu_opcode 0000.
- LW 0x0000A103 with iadder bits 10 → misaligned_load 1, rf_wr_en 0. LH with 10 → misaligned_load 0, load_size 01. SW with 01 → misaligned_store 1, mem_wr_req 0.
- Instruction 0x00000000 → illegal 1 and illegal_cnt 1. MUL 0x022081B3 → illegal with ENABLE_M=0; with ENABLE_M=1, mul_div_en 1 and illegal 0.
- FIFO_DEPTH=2, dec_ready_in=0, push A,B → instr_ready_out=0 and C is refused. Raise dec_ready_in → pops in order A,B, then C is accepted; push+pop in the same cycle keeps the count.
- Two entries queued plus trap_taken_in=1 with a valid input → next cycle dec_valid_out=0, the input is not accepted, illegal_cnt_out is unchanged; assert reset mid-stream → all outputs 0 immediately.
